// File: rtl/MD_pkg.sv
// Shared widths, states and defaults for the motion-update datapath.
package MD_pkg;

    localparam int PARTICLE_ID_WIDTH   = 4;
    localparam int OFFSET_WIDTH        = 8;
    localparam int OFFSET_STRUCT_WIDTH = 3 * OFFSET_WIDTH;
    localparam int FLOAT_WIDTH         = 32;
    localparam int FLOAT_STRUCT_WIDTH  = 3 * FLOAT_WIDTH;
    localparam int ELEMENT_WIDTH       = 2;

    localparam int MU_WB_DRAIN_CYCLES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } mu_wb_state_t;

endpackage

// File: rtl/mu_writeback_control.sv
// Motion-update writeback: packs returned particles densely into the next-iteration
// caches, closes the phase after an idle drain and flips the ping-pong bank.
//
// state   | meaning
// IDLE    | no phase open; valid data here is a protocol error
// COLLECT | writing particles, waiting for all cells to finish
// DRAIN   | still writing; counting idle cycles before closing
// DONE    | one cycle: publish count, flip bank
module mu_writeback_control
    import MD_pkg::*;
#(
    parameter int MAX_PARTICLES = 2**PARTICLE_ID_WIDTH,
    parameter int DRAIN_CYCLES  = MU_WB_DRAIN_CYCLES
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_MU_start,
    input  logic [OFFSET_STRUCT_WIDTH-1:0]           i_offset,
    input  logic [FLOAT_STRUCT_WIDTH-1:0]            i_vel,
    input  logic [ELEMENT_WIDTH-1:0]                 i_element,
    input  logic                                     i_data_valid,
    input  logic                                     i_MU_all_done,
    output logic [PARTICLE_ID_WIDTH-1:0]             o_pos_wr_addr,
    output logic [ELEMENT_WIDTH+OFFSET_STRUCT_WIDTH-1:0] o_pos_wr_data,
    output logic [PARTICLE_ID_WIDTH-1:0]             o_vel_wr_addr,
    output logic [FLOAT_STRUCT_WIDTH-1:0]            o_vel_wr_data,
    output logic                                     o_wr_en,
    output logic                                     o_bank_sel,
    output logic [PARTICLE_ID_WIDTH:0]               o_particle_num,
    output logic                                     o_wb_done,
    output logic                                     o_overflow,
    output logic                                     o_protocol_err
);

    localparam int PW     = PARTICLE_ID_WIDTH;
    localparam int CNT_W  = PARTICLE_ID_WIDTH + 1;
    localparam int PDW    = ELEMENT_WIDTH + OFFSET_STRUCT_WIDTH;
    localparam int IDLE_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_PARTICLES);
    localparam logic [IDLE_W-1:0] DRAIN_LAST = IDLE_W'(DRAIN_CYCLES - 1);

    mu_wb_state_t            state_q, state_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [PW-1:0]           wr_addr_q, wr_addr_d;
    logic [PDW-1:0]          pos_data_q, pos_data_d;
    logic [FLOAT_STRUCT_WIDTH-1:0] vel_data_q, vel_data_d;
    logic                    wb_done_q, wb_done_d;
    logic                    bank_q, bank_d;
    logic [CNT_W-1:0]        num_q, num_d;
    logic                    ovf_q, ovf_d;
    logic                    perr_q, perr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            idle_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            pos_data_q <= '0;
            vel_data_q <= '0;
            wb_done_q  <= 1'b0;
            bank_q     <= 1'b0;
            num_q      <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            pos_data_q <= pos_data_d;
            vel_data_q <= vel_data_d;
            wb_done_q  <= wb_done_d;
            bank_q     <= bank_d;
            num_q      <= num_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        idle_cnt_d = idle_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        pos_data_d = pos_data_q;
        vel_data_d = vel_data_q;
        wb_done_d  = 1'b0;
        bank_d     = bank_q;
        num_d      = num_q;
        ovf_d      = ovf_q;
        perr_d     = perr_q;

        // Writes are accepted in every open-phase state, including DONE.
        if (i_data_valid) begin
            if (state_q == IDLE) begin
                perr_d = 1'b1;
            end else if (wr_cnt_q == MAX_CNT) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d    = 1'b1;
                wr_addr_d  = wr_cnt_q[PW-1:0];
                pos_data_d = {i_element, i_offset};
                vel_data_d = i_vel;
                wr_cnt_d   = wr_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (i_MU_start) begin
                    state_d  = COLLECT;
                    wr_cnt_d = '0;
                end
            end
            COLLECT: begin
                if (i_MU_all_done) begin
                    state_d    = DRAIN;
                    idle_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (i_data_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == DRAIN_LAST) begin
                    state_d   = DONE;
                    wb_done_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                num_d   = wr_cnt_q;
                bank_d  = ~bank_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_pos_wr_addr  = wr_addr_q;
    assign o_vel_wr_addr  = wr_addr_q;
    assign o_pos_wr_data  = pos_data_q;
    assign o_vel_wr_data  = vel_data_q;
    assign o_wr_en        = wr_en_q;
    assign o_bank_sel     = bank_q;
    assign o_particle_num = num_q;
    assign o_wb_done      = wb_done_q;
    assign o_overflow     = ovf_q;
    assign o_protocol_err = perr_q;

endmodule

// File: tb/tb_mu_writeback_control.sv
// Bench for mu_writeback_control: random particle phases against a phase-level model.
module tb_mu_writeback_control;
    import MD_pkg::*;

    localparam int PW    = PARTICLE_ID_WIDTH;
    localparam int PDW   = ELEMENT_WIDTH + OFFSET_STRUCT_WIDTH;
    localparam int VW    = FLOAT_STRUCT_WIDTH;
    localparam int MAXP  = 2**PARTICLE_ID_WIDTH;
    localparam int DRAIN = MU_WB_DRAIN_CYCLES;

    logic                           clk;
    logic                           rst_n;
    logic                           i_MU_start;
    logic [OFFSET_STRUCT_WIDTH-1:0] i_offset;
    logic [VW-1:0]                  i_vel;
    logic [ELEMENT_WIDTH-1:0]       i_element;
    logic                           i_data_valid;
    logic                           i_MU_all_done;
    logic [PW-1:0]                  o_pos_wr_addr;
    logic [PDW-1:0]                 o_pos_wr_data;
    logic [PW-1:0]                  o_vel_wr_addr;
    logic [VW-1:0]                  o_vel_wr_data;
    logic                           o_wr_en;
    logic                           o_bank_sel;
    logic [PW:0]                    o_particle_num;
    logic                           o_wb_done;
    logic                           o_overflow;
    logic                           o_protocol_err;

    mu_writeback_control dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_MU_start     (i_MU_start),
        .i_offset       (i_offset),
        .i_vel          (i_vel),
        .i_element      (i_element),
        .i_data_valid   (i_data_valid),
        .i_MU_all_done  (i_MU_all_done),
        .o_pos_wr_addr  (o_pos_wr_addr),
        .o_pos_wr_data  (o_pos_wr_data),
        .o_vel_wr_addr  (o_vel_wr_addr),
        .o_vel_wr_data  (o_vel_wr_data),
        .o_wr_en        (o_wr_en),
        .o_bank_sel     (o_bank_sel),
        .o_particle_num (o_particle_num),
        .o_wb_done      (o_wb_done),
        .o_overflow     (o_overflow),
        .o_protocol_err (o_protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]  addr;
        logic [PW-1:0]  vaddr;
        logic [PDW-1:0] pdata;
        logic [VW-1:0]  vdata;
        int             ed;
    } wr_rec_t;

    int n_cmp = 0;
    int n_fail = 0;

    // Edge-stamped log of everything the DUT writes or signals.
    int      cyc = 0;
    wr_rec_t obs_q[$];
    int      done_q[$];
    logic    bank_at_done = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (o_wr_en === 1'b1)
            obs_q.push_back('{o_pos_wr_addr, o_vel_wr_addr, o_pos_wr_data, o_vel_wr_data, cyc});
        if (o_wb_done === 1'b1) begin
            done_q.push_back(cyc);
            bank_at_done = o_bank_sel;
        end
    end

    // Reference model: a phase is a list of accepted particles packed from address 0.
    wr_rec_t        exp_q[$];
    int             exp_cnt = 0;
    logic           exp_bank = 1'b0;
    logic           exp_ovf = 1'b0;
    logic           exp_perr = 1'b0;
    int             last_ed = 0;
    logic [PDW-1:0] last_pd = '0;
    logic [VW-1:0]  last_vd = '0;

    task automatic drive(input logic s, input logic v, input logic d);
        logic [OFFSET_STRUCT_WIDTH-1:0] o;
        logic [VW-1:0]                  w;
        logic [ELEMENT_WIDTH-1:0]       e;
        o = OFFSET_STRUCT_WIDTH'({$urandom, $urandom});
        w = VW'({$urandom, $urandom, $urandom});
        e = ELEMENT_WIDTH'($urandom);
        i_MU_start    = s;
        i_data_valid  = v;
        i_MU_all_done = d;
        i_offset      = o;
        i_vel         = w;
        i_element     = e;
        last_pd = {e, o};
        last_vd = w;
        @(posedge clk);
        #1;
        last_ed = cyc;
        @(negedge clk);
    endtask

    task automatic model_valid();
        if (exp_cnt < MAXP) begin
            exp_q.push_back('{PW'(exp_cnt), PW'(exp_cnt), last_pd, last_vd, last_ed});
            exp_cnt++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_MU_start = 1'b0; i_data_valid = 1'b0; i_MU_all_done = 1'b0;
        i_offset = '0; i_vel = '0; i_element = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_bank = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_phase(input string name, input int n_pre, input int gap_max, input int late_gap);
        int last_evt;
        obs_q.delete(); done_q.delete(); exp_q.delete();
        exp_cnt = 0;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n_pre; i++) begin
            repeat ($urandom_range(gap_max, 0)) drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b0);
            model_valid();
        end
        drive(1'b0, 1'b0, 1'b1);
        last_evt = last_ed;
        if (late_gap >= 0) begin
            repeat (late_gap) drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b0);
            model_valid();
            last_evt = last_ed;
        end
        for (int k = 0; k < DRAIN + 8 && done_q.size() == 0; k++) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].vaddr !== exp_q[i].addr ||
                obs_q[i].pdata !== exp_q[i].pdata || obs_q[i].vdata !== exp_q[i].vdata ||
                obs_q[i].ed != exp_q[i].ed) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got addr=%0d vaddr=%0d edge=%0d pdata=%h vdata=%h want addr=%0d edge=%0d pdata=%h vdata=%h",
                         name, i, obs_q[i].addr, obs_q[i].vaddr, obs_q[i].ed, obs_q[i].pdata, obs_q[i].vdata,
                         exp_q[i].addr, exp_q[i].ed, exp_q[i].pdata, exp_q[i].vdata);
            end
        end
        n_cmp++;
        if (done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL %s wb_done_pulses: got %0d want 1", name, done_q.size());
        end
        if (done_q.size() > 0) begin
            n_cmp++;
            if (done_q[0] != last_evt + DRAIN) begin
                n_fail++;
                $display("FAIL %s wb_done_edge: got %0d want %0d", name, done_q[0], last_evt + DRAIN);
            end
            n_cmp++;
            if (bank_at_done !== exp_bank) begin
                n_fail++;
                $display("FAIL %s bank_during_done: got %b want %b", name, bank_at_done, exp_bank);
            end
            exp_bank = ~exp_bank;
        end
        n_cmp++;
        if (o_bank_sel !== exp_bank) begin
            n_fail++;
            $display("FAIL %s bank_sel: got %b want %b", name, o_bank_sel, exp_bank);
        end
        n_cmp++;
        if (o_particle_num !== (PW+1)'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s particle_num: got %0d want %0d", name, o_particle_num, exp_cnt);
        end
        n_cmp++;
        if (o_overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %b want %b", name, o_overflow, exp_ovf);
        end
        n_cmp++;
        if (o_protocol_err !== exp_perr) begin
            n_fail++;
            $display("FAIL %s protocol_err: got %b want %b", name, o_protocol_err, exp_perr);
        end
        n_cmp++;
        if (o_wb_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wb_done_after: got %b want 0", name, o_wb_done);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if (o_wr_en !== 1'b0 || o_wb_done !== 1'b0 || o_bank_sel !== 1'b0 ||
            o_overflow !== 1'b0 || o_protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s flags: got wr_en=%b wb_done=%b bank=%b ovf=%b perr=%b want all 0",
                     name, o_wr_en, o_wb_done, o_bank_sel, o_overflow, o_protocol_err);
        end
        n_cmp++;
        if (o_particle_num !== '0 || o_pos_wr_addr !== '0 || o_vel_wr_addr !== '0 ||
            o_pos_wr_data !== '0 || o_vel_wr_data !== '0) begin
            n_fail++;
            $display("FAIL %s data: got num=%0d paddr=%0d vaddr=%0d pdata=%h vdata=%h want all 0",
                     name, o_particle_num, o_pos_wr_addr, o_vel_wr_addr, o_pos_wr_data, o_vel_wr_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_MU_start = 1'b0; i_data_valid = 1'b0; i_MU_all_done = 1'b0;
        i_offset = '0; i_vel = '0; i_element = '0;
        #2;
        check_all_zero("reset_asserted");
        apply_reset();
        check_all_zero("reset_released");
    endtask

    task automatic test_single_phase();
        run_phase("five_consecutive", 5, 0, -1);
    endtask

    task automatic test_drain_restart();
        run_phase("drain_restart", 4, 0, 10);
    endtask

    task automatic test_protocol_err();
        obs_q.delete();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        exp_perr = 1'b1;
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_valid_writes: got %0d want 0", obs_q.size());
        end
        n_cmp++;
        if (o_protocol_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_valid_protocol_err: got %b want 1", o_protocol_err);
        end
    endtask

    task automatic test_back_to_back();
        run_phase("b2b_first", 3, 0, -1);
        run_phase("b2b_second", 7, 0, -1);
    endtask

    task automatic test_random_phases();
        for (int p = 0; p < 4; p++)
            run_phase("random", $urandom_range(12, 1), 2, int'($urandom_range(15, 0)) - 1);
    endtask

    task automatic test_overflow();
        run_phase("overflow", MAXP + 2, 0, -1);
    endtask

    task automatic test_reset_mid_phase();
        apply_reset();
        obs_q.delete();
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs_q.size() !== 3) begin
            n_fail++;
            $display("FAIL mid_reset_prewrites: got %0d want 3", obs_q.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        exp_bank = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0;
        run_phase("after_mid_reset", 2, 1, -1);
    endtask

    initial begin
        test_reset();
        test_single_phase();
        test_drain_restart();
        test_protocol_err();
        test_back_to_back();
        test_random_phases();
        test_overflow();
        test_reset_mid_phase();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
